// File: rtl/ring_decoder.sv
// ring_decoder
//   Receive-side companion to a WIDTH-bit one-hot ring counter. Each sample
//   taken while in_valid is high is checked for a legal one-hot code and
//   decoded to a binary index. A HUNT/SYNC/LOCKED state machine checks that
//   successive samples follow the rotate-left sequence (0001->0010->0100->1000
//   ->0001 for WIDTH=4). Downstream logic should trust index only while
//   locked is high.
//
//   Optional build macro: RING_ERR_CNT_EN adds the err_count output, a
//   saturating total of err_illegal/err_seq pulses.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   ring_in      in   [WIDTH-1:0] ring code under test
//   in_valid     in   ring_in is sampled only while high
//   index        out  [IDX_W-1:0] bit position of the last legal sample
//   index_valid  out  pulse: previous sample was legal
//   locked       out  high while the FSM is LOCKED
//   err_illegal  out  pulse: previous sample was not exactly one bit set
//   err_seq      out  pulse: previous sample legal but out of sequence
//   err_count    out  [ERR_CNT_W-1:0] saturating error total (RING_ERR_CNT_EN)
//
//   All outputs are registered and reflect the sample taken on the previous
//   edge.

module ring_decoder #(
  parameter int WIDTH      = 4,
  parameter int IDX_W      = 2,
  parameter int LOCK_COUNT = 2,
  parameter int MISS_LIMIT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             in_valid,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_seq
`ifdef RING_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  // Counters only need to reach their limits.
  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int MS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [MC_W-1:0] LOCK_CNT_V = MC_W'(LOCK_COUNT);
  localparam logic [MS_W-1:0] MISS_LIM_V = MS_W'(MISS_LIMIT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] expected, expected_next;
  logic [MC_W-1:0]  match_cnt, match_cnt_next;
  logic [MS_W-1:0]  miss_cnt, miss_cnt_next;
  logic [IDX_W-1:0] index_next;
  logic             index_valid_next;
  logic             err_illegal_next;
  logic             err_seq_next;

  // ---------------------------------------------------------------------------
  // Sample qualification
  // ---------------------------------------------------------------------------
  logic             legal;
  logic             match;
  logic [WIDTH-1:0] rot_in;
  logic [WIDTH-1:0] rot_exp;
  logic [IDX_W-1:0] code_idx;
  logic [MC_W-1:0]  match_inc;
  logic [MS_W-1:0]  miss_inc;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign legal     = (ring_in != '0) &&
                     ((ring_in & (ring_in - WIDTH'(1))) == '0);
  // An illegal code never counts as a match, even against a corrupt expected.
  assign match     = legal && (ring_in == expected);
  assign rot_in    = {ring_in[WIDTH-2:0], ring_in[WIDTH-1]};
  assign rot_exp   = {expected[WIDTH-2:0], expected[WIDTH-1]};
  assign match_inc = match_cnt + MC_W'(1);
  assign miss_inc  = miss_cnt + MS_W'(1);

  // One-hot to binary; only meaningful when legal is high.
  always_comb begin
    code_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) code_idx = IDX_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_next = state;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (legal) state_next = SYNC;
        end
        SYNC: begin
          if (!legal)                               state_next = HUNT;
          else if (match && match_inc == LOCK_CNT_V) state_next = LOCKED;
        end
        LOCKED: begin
          if (!match && miss_inc == MISS_LIM_V) state_next = HUNT;
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    expected_next    = expected;
    match_cnt_next   = match_cnt;
    miss_cnt_next    = miss_cnt;
    index_next       = index;
    index_valid_next = 1'b0;
    err_illegal_next = 1'b0;
    err_seq_next     = 1'b0;

    if (in_valid) begin
      // Decode and legality flags are independent of state.
      if (legal) begin
        index_next       = code_idx;
        index_valid_next = 1'b1;
      end
      err_illegal_next = !legal;

      unique case (state)
        HUNT: begin
          if (legal) begin
            expected_next  = rot_in;
            match_cnt_next = '0;
          end
        end
        SYNC: begin
          if (legal) begin
            // Track the received sequence in both cases; a mismatch re-seeds.
            expected_next = rot_in;
            if (match) begin
              match_cnt_next = match_inc;
              if (match_inc == LOCK_CNT_V) miss_cnt_next = '0;
            end else begin
              err_seq_next   = 1'b1;
              match_cnt_next = '0;
            end
          end
        end
        LOCKED: begin
          // Flywheel: expected keeps rotating whether or not the sample fits.
          expected_next = rot_exp;
          if (match) begin
            miss_cnt_next = '0;
          end else begin
            err_seq_next  = legal;
            miss_cnt_next = (miss_inc == MISS_LIM_V) ? '0 : miss_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      expected    <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      expected    <= expected_next;
      match_cnt   <= match_cnt_next;
      miss_cnt    <= miss_cnt_next;
      index       <= index_next;
      index_valid <= index_valid_next;
      err_illegal <= err_illegal_next;
      err_seq     <= err_seq_next;
    end
  end

  // state is itself a register, so locked is registered too.
  assign locked = (state == LOCKED);

`ifdef RING_ERR_CNT_EN
  // Saturating error total; counts the same edges that raise either pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if ((err_illegal_next || err_seq_next) && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`endif

endmodule
